code_set_verifier: RTL and testbench
====================================

// Module: code_set_verifier
// PURPOSE
//  Checks a code set in the shared codes RAM after populate_candidates has written it.
//  Reads set_len 8-bit codes starting at base_addr and computes the Hamming distance of every pair.
//  Reports the smallest distance found and the first pair below min_dist.
//  find_best_iso uses pass/min_found to accept a candidate set before the isolation search.
// PARAMETERS
//  RD_LAT    1   RAM read latency in clocks, from the addr register update to valid rd_data (1..3)
//  STOP_FAIL 0   1: stop at the first pair below min_dist; 0: scan all pairs so min_found is exact
// PORTS
//  clock      in   1  system clock; all logic on posedge
//  reset      in   1  synchronous, active-high
//  start      in   1  level request; passes through a 2-flop sync (start_1, start_2)
//  base_addr  in   8  RAM address of code[0]; sampled on the start_2 rising edge
//  set_len    in   8  number of codes (0..255); sampled with base_addr
//  min_dist   in   4  required minimum pairwise distance; sampled with base_addr
//  addr       out  8  RAM read address, registered; base_addr + index, mod 256
//  rd_data    in   8  RAM read data, valid RD_LAT clocks after addr changes
//  busy       out  1  high from the accepted start until complete
//  complete   out  1  one-clock pulse when results are valid
//  pass       out  1  1 = no pair has distance < min_dist; held until the next accepted start
//  min_found  out  4  smallest pairwise distance seen (0..8); 4'hF = no pairs compared
//  fail_i     out  8  index i of the first failing pair (i<j); 0 if pass
//  fail_j     out  8  index j of the first failing pair; 0 if pass
// BEHAVIOUR
//  Reset values: state=IDLE, addr=0, busy=0, complete=0, pass=0, min_found=4'hF, fail_i=0,
//    fail_j=0, sync flops=0.
//  Start is accepted only in IDLE on the rising edge of start_2. A start while busy is ignored.
//    Start held high does not retrigger; it must drop before the next run.
//  Accepted start: latch the inputs; set i=0, min_found=F, pass=1, fail_i/j=0, busy=1.
//  State machine:
//    IDLE -> CHK   on accepted start
//    CHK           if set_len<2 -> DONE (pass=1, min_found=F); else -> A_ADR
//    A_ADR         addr<=base+i; wait RD_LAT clocks (A_WT)
//    A_WT          capture a_reg<=rd_data; j<=i+1 -> B_ADR
//    B_ADR         addr<=base+j; wait RD_LAT (B_WT)
//    B_WT          capture b_reg<=rd_data -> DIST
//    DIST          dist<=popcount(a_reg^b_reg), registered 4-bit -> CMP
//    CMP           if dist<min_found: min_found<=dist
//                  if dist<min_dist and pass: pass<=0, fail_i<=i, fail_j<=j;
//                    if STOP_FAIL -> DONE
//                  if j==set_len-1: i<=i+1; if i+1==set_len-1 -> DONE, else -> A_ADR
//                  else j<=j+1 -> B_ADR
//    DONE          complete<=1 for one clock, busy<=0 -> IDLE
//  Cycle budget (RD_LAT=1), from the accepted start edge to the complete pulse:
//    3 + 2*(set_len-1) + 4*P clocks, where P = set_len*(set_len-1)/2.
//  Index counters are 8 bits. Compare j==set_len-1 before incrementing, so there is no wrap at 255.
//    The addr sum wraps mod 256.
//  min_dist=0: every pair passes; min_found is still computed.
//  Duplicate codes: dist=0, so min_found=0; they fail if min_dist>=1.
//  Reset mid-run: abort on the next edge and return to reset values; no complete pulse.
//  The RAM is read-only from this block; it has no write port.
// TESTING
//  T1 codes {00,0F,F0,FF}, len 4, min 4 -> pass=1, min_found=4, complete after 3+6+24=33 clk
//  T2 codes {00,03,FF}, len 3, min 4 -> pass=0, fail_i=0, fail_j=1, min_found=2 (STOP_FAIL=0)
//  T3 T2 with STOP_FAIL=1 -> pass=0, fail (0,1), complete after 3+2+4=9 clk, min_found=2
//  T4 len 0 and len 1 -> pass=1, min_found=F, complete 2 clk after the accepted start, addr unchanged
//  T5 codes {55,55}, min 1 -> pass=0, min_found=0; start re-pulsed while busy -> ignored, one complete
//  T6 len 20, assert reset at pair 10 -> all outputs at reset values next clk; new start -> full run

Source files
------------

// File: rtl/code_set_verifier.sv
// Pairwise Hamming-distance checker for a code set held in the shared codes RAM.
// Reports the minimum distance seen and the first pair closer than min_dist.
module code_set_verifier #(
    parameter int RD_LAT    = 1,
    parameter bit STOP_FAIL = 1'b0
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_base_addr,
    input  logic [7:0] i_set_len,
    input  logic [3:0] i_min_dist,
    output logic [7:0] o_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_busy,
    output logic       o_complete,
    output logic       o_pass,
    output logic [3:0] o_min_found,
    output logic [7:0] o_fail_i,
    output logic [7:0] o_fail_j
);

    typedef enum logic [3:0] {
        IDLE, CHK, A_ADR, A_WT, B_ADR, B_WT, DIST, CMP, DONE
    } state_t;

    localparam logic [1:0] W_LAST = 2'(RD_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_start_1;
    logic       r_start_2;
    logic [7:0] r_base;
    logic [7:0] r_len;
    logic [3:0] r_min;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_dist;
    logic [1:0] r_wait;
    logic [7:0] r_addr;
    logic       r_busy;
    logic       r_complete;
    logic       r_pass;
    logic [3:0] r_min_found;
    logic [7:0] r_fail_i;
    logic [7:0] r_fail_j;

    logic w_start_rise;
    logic w_rd_ok;
    logic w_last_j;
    logic w_last_i;
    logic w_fail;
    logic w_stop;

    function automatic logic [3:0] popcnt(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) n = n + {3'b000, v[k]};
        return n;
    endfunction

    // start_2 is about to rise when start_1 is high and start_2 still low
    assign w_start_rise = r_start_1 & ~r_start_2;
    assign w_rd_ok      = (r_wait == W_LAST);
    assign w_last_j     = (r_j == r_len - 8'd1);
    assign w_last_i     = (r_i + 8'd1 == r_len - 8'd1);
    assign w_fail       = (r_dist < r_min) && r_pass;
    assign w_stop       = w_fail && STOP_FAIL;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start_rise) w_state_nxt = CHK;
            CHK:     w_state_nxt = (r_len < 8'd2) ? DONE : A_ADR;
            A_ADR:   w_state_nxt = A_WT;
            A_WT:    if (w_rd_ok) w_state_nxt = B_ADR;
            B_ADR:   w_state_nxt = B_WT;
            B_WT:    if (w_rd_ok) w_state_nxt = DIST;
            DIST:    w_state_nxt = CMP;
            CMP: begin
                if (w_stop)        w_state_nxt = DONE;
                else if (w_last_j) w_state_nxt = w_last_i ? DONE : A_ADR;
                else               w_state_nxt = B_ADR;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_start_1   <= 1'b0;
            r_start_2   <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_min       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_dist      <= '0;
            r_wait      <= '0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_complete  <= 1'b0;
            r_pass      <= 1'b0;
            r_min_found <= 4'hF;
            r_fail_i    <= '0;
            r_fail_j    <= '0;
        end else begin
            r_start_1  <= i_start;
            r_start_2  <= r_start_1;
            r_state    <= w_state_nxt;
            r_complete <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_start_rise) begin
                        r_base      <= i_base_addr;
                        r_len       <= i_set_len;
                        r_min       <= i_min_dist;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_min_found <= 4'hF;
                        r_pass      <= 1'b1;
                        r_fail_i    <= '0;
                        r_fail_j    <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                A_ADR: begin
                    r_addr <= r_base + r_i;
                    r_wait <= '0;
                end
                A_WT: begin
                    r_wait <= r_wait + 2'd1;
                    if (w_rd_ok) begin
                        r_a <= i_rd_data;
                        r_j <= r_i + 8'd1;
                    end
                end
                B_ADR: begin
                    r_addr <= r_base + r_j;
                    r_wait <= '0;
                end
                B_WT: begin
                    r_wait <= r_wait + 2'd1;
                    if (w_rd_ok) r_b <= i_rd_data;
                end
                DIST: r_dist <= popcnt(r_a ^ r_b);
                CMP: begin
                    if (r_dist < r_min_found) r_min_found <= r_dist;
                    if (w_fail) begin
                        r_pass   <= 1'b0;
                        r_fail_i <= r_i;
                        r_fail_j <= r_j;
                    end
                    // j is tested before it moves, so no index ever wraps at 255
                    if (!w_stop) begin
                        if (w_last_j) r_i <= r_i + 8'd1;
                        else          r_j <= r_j + 8'd1;
                    end
                end
                DONE: begin
                    r_complete <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_addr      = r_addr;
    assign o_busy      = r_busy;
    assign o_complete  = r_complete;
    assign o_pass      = r_pass;
    assign o_min_found = r_min_found;
    assign o_fail_i    = r_fail_i;
    assign o_fail_j    = r_fail_j;

endmodule

// File: tb/tb_code_set_verifier.sv
// Randomised bench for code_set_verifier: two instances (scan-all and stop-on-fail)
// checked every cycle against a pair-enumerating reference model.
module tb_code_set_verifier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] base;
    logic [7:0] len;
    logic [3:0] mind;
    logic [7:0] mem [256];

    logic [7:0] addr0, addr1, rd0, rd1, fi0, fi1, fj0, fj1;
    logic       busy0, busy1, cpl0, cpl1, pass0, pass1;
    logic [3:0] mf0, mf1;

    assign rd0 = mem[addr0];
    assign rd1 = mem[addr1];

    code_set_verifier #(.RD_LAT(1), .STOP_FAIL(1'b0)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_start(start),
        .i_base_addr(base), .i_set_len(len), .i_min_dist(mind),
        .o_addr(addr0), .i_rd_data(rd0), .o_busy(busy0),
        .o_complete(cpl0), .o_pass(pass0), .o_min_found(mf0),
        .o_fail_i(fi0), .o_fail_j(fj0));

    code_set_verifier #(.RD_LAT(1), .STOP_FAIL(1'b1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_start(start),
        .i_base_addr(base), .i_set_len(len), .i_min_dist(mind),
        .o_addr(addr1), .i_rd_data(rd1), .o_busy(busy1),
        .o_complete(cpl1), .o_pass(pass1), .o_min_found(mf1),
        .o_fail_i(fi1), .o_fail_j(fj1));

    typedef struct {
        logic       pass;
        logic [3:0] mf;
        logic [7:0] fi;
        logic [7:0] fj;
        logic [7:0] addr;
        int         lat;
    } res_t;

    typedef struct {
        res_t prev;
        res_t cur;
        int   t0;
        int   skip;
    } exp_t;

    localparam int NEVER = 1 << 30;

    exp_t ex [2];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   cpl_cnt [2];
    int   cpl_cyc [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            if (fails < 40)
                $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, got, want);
        end
    endtask

    // Enumerate pairs i<j in scan order; each A read costs 2 clocks, each pair 4,
    // plus one CHK and one DONE clock; lat is the edge offset of the complete pulse.
    task automatic model(input int b, input int l, input int m, input bit st,
                         input logic [7:0] pa, output res_t r);
        int d;
        bit stop;
        r.pass = 1'b1; r.mf = 4'hF; r.fi = '0; r.fj = '0;
        r.addr = pa; r.lat = 2; stop = 1'b0;
        if (l >= 2)
            for (int i = 0; i < l - 1 && !stop; i++) begin
                r.lat += 2;
                for (int j = i + 1; j < l && !stop; j++) begin
                    r.lat += 4;
                    d = $countones(mem[8'(b + i)] ^ mem[8'(b + j)]);
                    r.addr = 8'(b + j);
                    if (d < int'(r.mf)) r.mf = 4'(d);
                    if (d < m && r.pass) begin
                        r.pass = 1'b0; r.fi = 8'(i); r.fj = 8'(j);
                        stop = st;
                    end
                end
            end
    endtask

    task automatic cmp_dut(input int d, input logic bz, input logic cp,
                           input logic ps, input logic [3:0] mf,
                           input logic [7:0] fi, input logic [7:0] fj,
                           input logic [7:0] ad);
        exp_t e;
        e = ex[d];
        if (cp === 1'b1) begin
            cpl_cnt[d]++;
            cpl_cyc[d] = cyc;
        end
        if (cyc < e.skip) return;
        if (cyc < e.t0) begin
            chk("idle_busy", d, 32'(bz), 0);
            chk("idle_complete", d, 32'(cp), 0);
            chk("held_pass", d, 32'(ps), 32'(e.prev.pass));
            chk("held_min", d, 32'(mf), 32'(e.prev.mf));
            chk("held_fail_i", d, 32'(fi), 32'(e.prev.fi));
            chk("held_fail_j", d, 32'(fj), 32'(e.prev.fj));
            chk("held_addr", d, 32'(ad), 32'(e.prev.addr));
        end else if (cyc < e.t0 + e.cur.lat) begin
            chk("run_busy", d, 32'(bz), 1);
            chk("run_complete", d, 32'(cp), 0);
            if (cyc == e.t0) begin
                chk("init_pass", d, 32'(ps), 1);
                chk("init_min", d, 32'(mf), 32'hF);
                chk("init_fail_i", d, 32'(fi), 0);
                chk("init_fail_j", d, 32'(fj), 0);
                chk("init_addr", d, 32'(ad), 32'(e.prev.addr));
            end
        end else begin
            chk("end_busy", d, 32'(bz), 0);
            chk("end_complete", d, 32'(cp), 32'(cyc == e.t0 + e.cur.lat));
            chk("res_pass", d, 32'(ps), 32'(e.cur.pass));
            chk("res_min", d, 32'(mf), 32'(e.cur.mf));
            chk("res_fail_i", d, 32'(fi), 32'(e.cur.fi));
            chk("res_fail_j", d, 32'(fj), 32'(e.cur.fj));
            chk("res_addr", d, 32'(ad), 32'(e.cur.addr));
        end
    endtask

    always @(negedge clk) begin
        cmp_dut(0, busy0, cpl0, pass0, mf0, fi0, fj0, addr0);
        cmp_dut(1, busy1, cpl1, pass1, mf1, fi1, fj1, addr1);
    end

    task automatic set_reset_exp(input int sk);
        res_t rr;
        rr.pass = 1'b0; rr.mf = 4'hF; rr.fi = '0; rr.fj = '0;
        rr.addr = '0; rr.lat = 0;
        for (int d = 0; d < 2; d++) begin
            ex[d].prev = rr;
            ex[d].cur  = rr;
            ex[d].t0   = NEVER;
            ex[d].skip = sk;
        end
    endtask

    // Called #2 after an edge; start_2 rises, and the run is accepted, two edges later.
    task automatic launch(input logic [7:0] b, input logic [7:0] l, input logic [3:0] m);
        res_t r;
        for (int d = 0; d < 2; d++) begin
            ex[d].prev = ex[d].cur;
            model(int'(b), int'(l), int'(m), d == 1, ex[d].prev.addr, r);
            ex[d].cur = r;
            ex[d].t0  = cyc + 2;
        end
        base = b; len = l; mind = m; start = 1'b1;
    endtask

    task automatic run(input logic [7:0] b, input logic [7:0] l, input logic [3:0] m);
        int tend;
        @(posedge clk); #2;
        launch(b, l, m);
        repeat (3) @(posedge clk);
        #2 start = 1'b0;
        tend = ex[0].t0 + ex[0].cur.lat;
        if (ex[1].t0 + ex[1].cur.lat > tend) tend = ex[1].t0 + ex[1].cur.lat;
        tend += 2;
        while (cyc < tend) @(negedge clk);
        @(posedge clk); #2;
    endtask

    task automatic put(input logic [7:0] b, input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic [7:0] c3);
        mem[b] = c0;
        mem[8'(b + 1)] = c1;
        mem[8'(b + 2)] = c2;
        mem[8'(b + 3)] = c3;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        logic [7:0] msk, rb, rl;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; mind = '0;
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom_range(0, 255));
        cpl_cnt[0] = 0; cpl_cnt[1] = 0;
        cpl_cyc[0] = 0; cpl_cyc[1] = 0;
        set_reset_exp(1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // T1: {00,0F,F0,FF}, min 4 -> pass, min 4, pulse in clock 33
        put(8'h10, 8'h00, 8'h0F, 8'hF0, 8'hFF);
        run(8'h10, 8'd4, 4'd4);
        chk("T1_pass", 0, 32'(pass0), 1);
        chk("T1_min", 0, 32'(mf0), 4);
        chk("T1_cycles", 0, cpl_cyc[0] - ex[0].t0 + 1, 33);

        // T2/T3: {00,03,FF} across the 255->0 address wrap
        put(8'hFE, 8'h00, 8'h03, 8'hFF, 8'h77);
        run(8'hFE, 8'd3, 4'd4);
        chk("T2_pass", 0, 32'(pass0), 0);
        chk("T2_fail_i", 0, 32'(fi0), 0);
        chk("T2_fail_j", 0, 32'(fj0), 1);
        chk("T2_min", 0, 32'(mf0), 2);
        chk("T3_pass", 1, 32'(pass1), 0);
        chk("T3_fail_j", 1, 32'(fj1), 1);
        chk("T3_min", 1, 32'(mf1), 2);
        chk("T3_cycles", 1, cpl_cyc[1] - ex[1].t0 + 1, 9);

        // T4: trivial sets finish two edges after acceptance
        run(8'h40, 8'd0, 4'd3);
        chk("T4_len0_edges", 0, cpl_cyc[0] - ex[0].t0, 2);
        chk("T4_len0_min", 0, 32'(mf0), 32'hF);
        run(8'h80, 8'd1, 4'd3);
        chk("T4_len1_edges", 1, cpl_cyc[1] - ex[1].t0, 2);
        chk("T4_len1_pass", 1, 32'(pass1), 1);

        // T5: duplicates, with start re-pulsed while busy
        put(8'h20, 8'h55, 8'h55, 8'h00, 8'h00);
        n0 = cpl_cnt[0];
        @(posedge clk); #2;
        launch(8'h20, 8'd2, 4'd1);
        repeat (3) @(posedge clk);
        #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 start = 1'b1;
        repeat (2) @(posedge clk);
        #2 start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        chk("T5_one_complete", 0, cpl_cnt[0] - n0, 1);
        chk("T5_pass", 0, 32'(pass0), 0);
        chk("T5_min", 0, 32'(mf0), 0);

        // T6: reset during pair 10 of a 20-code set, then a full rerun
        @(posedge clk); #2;
        launch(8'h60, 8'd20, 4'd3);
        repeat (3) @(posedge clk);
        #2 start = 1'b0;
        while (cyc < ex[0].t0 + 43) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        set_reset_exp(cyc + 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        chk("T6_busy", 0, 32'(busy0), 0);
        chk("T6_min", 0, 32'(mf0), 32'hF);
        run(8'h60, 8'd20, 4'd3);

        // random sets; masking the codes makes close and duplicate pairs common
        for (int t = 0; t < 25; t++) begin
            msk = 8'($urandom_range(0, 255)) | 8'h01;
            rb  = 8'($urandom_range(0, 255));
            rl  = 8'($urandom_range(0, 16));
            for (int k = 0; k < 20; k++)
                mem[8'(int'(rb) + k)] = 8'($urandom_range(0, 255)) & msk;
            run(rb, rl, 4'($urandom_range(0, 9)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
